// File: rtl/tpx3_shutter_seq_if.sv
// ============================================================================
// Module : tpx3_shutter_seq_if
// Brief  : Configuration, command and chip-line bundle for tpx3_shutter_seq.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface tpx3_shutter_seq_if #(
    parameter int CNT_WIDTH = 32,
    parameter int REP_WIDTH = 16,
    parameter int TP_WIDTH  = 16
);
    logic                 START;
    logic                 ABORT;
    logic                 CONF_T0_EN;
    logic [CNT_WIDTH-1:0] CONF_DELAY;
    logic [CNT_WIDTH-1:0] CONF_SHUTTER_LEN;
    logic [CNT_WIDTH-1:0] CONF_GAP;
    logic [REP_WIDTH-1:0] CONF_REPEAT;
    logic                 CONF_TP_EN;
    logic [TP_WIDTH-1:0]  CONF_TP_PERIOD;
    logic [TP_WIDTH-1:0]  CONF_TP_HIGH;
    logic                 SHUTTER;
    logic                 TPULSE;
    logic                 T0_SYNC;
    logic                 BUSY;
    logic                 DONE;
    logic [REP_WIDTH-1:0] FRAME_CNT;

    modport master (
        output START, ABORT, CONF_T0_EN, CONF_DELAY, CONF_SHUTTER_LEN, CONF_GAP,
               CONF_REPEAT, CONF_TP_EN, CONF_TP_PERIOD, CONF_TP_HIGH,
        input  SHUTTER, TPULSE, T0_SYNC, BUSY, DONE, FRAME_CNT
    );

    modport slave (
        input  START, ABORT, CONF_T0_EN, CONF_DELAY, CONF_SHUTTER_LEN, CONF_GAP,
               CONF_REPEAT, CONF_TP_EN, CONF_TP_PERIOD, CONF_TP_HIGH,
        output SHUTTER, TPULSE, T0_SYNC, BUSY, DONE, FRAME_CNT
    );
endinterface

`default_nettype wire

// File: rtl/tpx3_shutter_seq.sv
// ============================================================================
// Module : tpx3_shutter_seq
// Brief  : Timepix3 Shutter / ExtTPulse / T0_Sync sequencer in the BUS_CLK domain.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tpx3_shutter_seq #(
    parameter int CNT_WIDTH = 32,
    parameter int REP_WIDTH = 16,
    parameter int TP_WIDTH  = 16
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    tpx3_shutter_seq_if.slave    bus
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [REP_WIDTH-1:0] C_REP_ONE = {{(REP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TP_WIDTH-1:0]  C_TP_ONE  = {{(TP_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DELAY = 3'd2,
        ST_OPEN  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [TP_WIDTH-1:0]  phase_q, phase_d;
    logic [REP_WIDTH-1:0] frame_q, frame_d;

    logic [CNT_WIDTH-1:0] delay_q, len_m1_q, gap_q;
    logic [REP_WIDTH-1:0] rep_q;
    logic                 tp_en_q;
    logic [TP_WIDTH-1:0]  period_q, high_q;

    logic                 shutter_q, tpulse_q, t0_q, busy_q, done_q;
    logic                 tpulse_d, t0_d, done_d;
    logic                 w_accept;
    logic [REP_WIDTH-1:0] w_frame_inc;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        frame_d     = frame_q;
        t0_d        = 1'b0;
        done_d      = 1'b0;
        w_accept    = 1'b0;
        w_frame_inc = frame_q + C_REP_ONE;

        case (state_q)
            ST_IDLE: begin
                if (bus.START && !bus.ABORT) begin
                    state_d  = ST_SYNC;
                    frame_d  = '0;
                    t0_d     = bus.CONF_T0_EN;
                    w_accept = 1'b1;
                end
            end
            ST_SYNC: begin
                if (delay_q != '0) begin
                    state_d = ST_DELAY;
                    cnt_d   = delay_q - C_CNT_ONE;
                end else begin
                    state_d = ST_OPEN;
                    cnt_d   = len_m1_q;
                    phase_d = '0;
                end
            end
            ST_DELAY, ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_OPEN;
                    cnt_d   = len_m1_q;
                    phase_d = '0;
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            ST_OPEN: begin
                if (cnt_q == '0) begin
                    frame_d = w_frame_inc;
                    if (rep_q != '0 && w_frame_inc == rep_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (gap_q != '0) begin
                        state_d = ST_GAP;
                        cnt_d   = gap_q - C_CNT_ONE;
                    end else begin
                        // Back-to-back frames: shutter stays high, phase restarts.
                        state_d = ST_OPEN;
                        cnt_d   = len_m1_q;
                        phase_d = '0;
                    end
                end else begin
                    cnt_d   = cnt_q - C_CNT_ONE;
                    phase_d = (phase_q == period_q - C_TP_ONE) ? '0 : phase_q + C_TP_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over a simultaneous frame end, so a partial frame is never counted.
        if (state_q != ST_IDLE && bus.ABORT) begin
            state_d = ST_IDLE;
            cnt_d   = cnt_q;
            phase_d = phase_q;
            frame_d = frame_q;
            done_d  = 1'b1;
        end

        tpulse_d = (state_d == ST_OPEN) && tp_en_q && (period_q != '0) && (phase_d < high_q);
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            phase_q   <= '0;
            frame_q   <= '0;
            delay_q   <= '0;
            len_m1_q  <= '0;
            gap_q     <= '0;
            rep_q     <= '0;
            tp_en_q   <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            shutter_q <= 1'b0;
            tpulse_q  <= 1'b0;
            t0_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            frame_q   <= frame_d;
            shutter_q <= (state_d == ST_OPEN);
            tpulse_q  <= tpulse_d;
            t0_q      <= t0_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= done_d;
            if (w_accept) begin
                delay_q  <= bus.CONF_DELAY;
                len_m1_q <= (bus.CONF_SHUTTER_LEN == '0) ? '0 : bus.CONF_SHUTTER_LEN - C_CNT_ONE;
                gap_q    <= bus.CONF_GAP;
                rep_q    <= bus.CONF_REPEAT;
                tp_en_q  <= bus.CONF_TP_EN;
                period_q <= bus.CONF_TP_PERIOD;
                high_q   <= bus.CONF_TP_HIGH;
            end
        end
    end

    assign bus.SHUTTER   = shutter_q;
    assign bus.TPULSE    = tpulse_q;
    assign bus.T0_SYNC   = t0_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.FRAME_CNT = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_tpx3_shutter_seq.sv
// ============================================================================
// Module : tb_tpx3_shutter_seq
// Brief  : Self-checking bench: directed table, corner sequences, random runs.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tpx3_shutter_seq;

    localparam int CW = 32;
    localparam int RW = 16;
    localparam int TW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tpx3_shutter_seq_if #(.CNT_WIDTH(CW), .REP_WIDTH(RW), .TP_WIDTH(TW)) bus();

    tpx3_shutter_seq #(.CNT_WIDTH(CW), .REP_WIDTH(RW), .TP_WIDTH(TW)) dut (
        .BUS_CLK (clk),
        .BUS_RST (rst),
        .bus     (bus)
    );

    typedef struct {
        int t0en; int delay; int len; int gap; int rep; int tpen; int per; int high;
    } cfg_t;

    typedef struct {
        cfg_t cfg;
        int   abort_at;
        int   e_sh; int e_tp; int e_t0; int e_busy; int e_done; int e_fc;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive_cfg(input cfg_t c);
        bus.CONF_T0_EN       = c.t0en[0];
        bus.CONF_DELAY       = CW'(c.delay);
        bus.CONF_SHUTTER_LEN = CW'(c.len);
        bus.CONF_GAP         = CW'(c.gap);
        bus.CONF_REPEAT      = RW'(c.rep);
        bus.CONF_TP_EN       = c.tpen[0];
        bus.CONF_TP_PERIOD   = TW'(c.per);
        bus.CONF_TP_HIGH     = TW'(c.high);
    endtask

    task automatic scramble_cfg();
        bus.CONF_T0_EN       = 1'($urandom);
        bus.CONF_DELAY       = $urandom;
        bus.CONF_SHUTTER_LEN = $urandom;
        bus.CONF_GAP         = $urandom;
        bus.CONF_REPEAT      = RW'($urandom);
        bus.CONF_TP_EN       = 1'($urandom);
        bus.CONF_TP_PERIOD   = TW'($urandom);
        bus.CONF_TP_HIGH     = TW'($urandom);
    endtask

    // Frames whose end edge is at or before edge e (edge 0 = start acceptance).
    function automatic int frames_by(input cfg_t c, input int e);
        int l;
        int first_end;
        l = (c.len == 0) ? 1 : c.len;
        first_end = 1 + c.delay + l;
        if (e < first_end) return 0;
        return (e - first_end) / (l + c.gap) + 1;
    endfunction

    task automatic run(input int id, input cfg_t c, input int abort_at, input bit noise,
                       output int n_sh, output int n_tp, output int n_t0,
                       output int n_busy, output int done_cyc, output int fc_end);
        int l, nat_end, stop, lim, ph, act, exp, fc_e;
        bit aborted, op, e_tp;
        l       = (c.len == 0) ? 1 : c.len;
        nat_end = (c.rep != 0) ? 1 + c.delay + (c.rep - 1) * (l + c.gap) + l : 1000000;
        aborted = (abort_at != 0) && (abort_at <= nat_end);
        stop    = aborted ? abort_at : nat_end;
        lim     = (stop < 3000) ? stop + 3 : 3000;
        n_sh = 0; n_tp = 0; n_t0 = 0; n_busy = 0; done_cyc = -1;
        drive_cfg(c);
        bus.START = 1'b1;
        bus.ABORT = 1'b0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc <= lim; cyc++) begin
            if (cyc < stop) begin
                op   = (cyc >= 1 + c.delay) && (((cyc - 1 - c.delay) % (l + c.gap)) < l);
                ph   = op ? (cyc - 1 - c.delay) % (l + c.gap) : 0;
                e_tp = 1'b0;
                if (op && c.tpen != 0 && c.per != 0) e_tp = (ph % c.per) < c.high;
                fc_e = frames_by(c, cyc);
                exp  = (fc_e << 5) | (int'(op) << 4) | (int'(e_tp) << 3)
                     | (int'(cyc == 0 && c.t0en != 0) << 2) | (1 << 1);
            end else begin
                fc_e = aborted ? frames_by(c, stop - 1) : c.rep;
                exp  = (fc_e << 5) | int'(cyc == stop);
            end
            act = int'({bus.FRAME_CNT, bus.SHUTTER, bus.TPULSE, bus.T0_SYNC, bus.BUSY, bus.DONE});
            check($sformatf("run%0d cyc%0d {fc,sh,tp,t0,busy,done}", id, cyc), act, exp);
            n_sh   += int'(bus.SHUTTER);
            n_tp   += int'(bus.TPULSE);
            n_t0   += int'(bus.T0_SYNC);
            n_busy += int'(bus.BUSY);
            if (bus.DONE && done_cyc < 0) done_cyc = cyc;
            bus.START = (noise && cyc + 1 <= stop) ? 1'($urandom) : 1'b0;
            bus.ABORT = (cyc + 1 == abort_at);
            if (noise) scramble_cfg();
            @(posedge clk); #1;
        end
        fc_end    = int'(bus.FRAME_CNT);
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t tbl[7];
        cfg_t c;
        int n_sh, n_tp, n_t0, n_busy, done_cyc, fc_end, cnt, ab;

        tbl[0] = '{'{1, 3, 5, 2, 2, 0, 0, 0}, 0, 10, 0, 1, 16, 16, 2};
        tbl[1] = '{'{0, 0, 0, 0, 3, 0, 0, 0}, 0, 3, 0, 0, 4, 4, 3};
        tbl[2] = '{'{1, 0, 10, 0, 1, 1, 4, 1}, 0, 10, 3, 1, 11, 11, 1};
        tbl[3] = '{'{1, 0, 10, 0, 1, 1, 0, 1}, 0, 10, 0, 1, 11, 11, 1};
        tbl[4] = '{'{1, 0, 10, 0, 1, 1, 4, 6}, 0, 10, 10, 1, 11, 11, 1};
        tbl[5] = '{'{0, 0, 5, 5, 0, 0, 0, 0}, 23, 12, 0, 0, 23, 23, 2};
        tbl[6] = '{'{1, 3, 5, 2, 2, 0, 0, 0}, 0, 10, 0, 1, 16, 16, 2};

        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        c = '{0, 0, 0, 0, 0, 0, 0, 0};
        drive_cfg(c);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset outputs", int'({bus.FRAME_CNT, bus.SHUTTER, bus.TPULSE, bus.T0_SYNC, bus.BUSY, bus.DONE}), 0);

        // START and ABORT together in IDLE must not launch a run.
        bus.START = 1'b1;
        bus.ABORT = 1'b1;
        @(posedge clk); #1;
        check("start+abort busy", int'(bus.BUSY), 0);
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        @(posedge clk); #1;
        check("start+abort busy later", int'(bus.BUSY), 0);

        for (int i = 0; i < 7; i++) begin
            run(i, tbl[i].cfg, tbl[i].abort_at, 1'b1, n_sh, n_tp, n_t0, n_busy, done_cyc, fc_end);
            check($sformatf("vec%0d shutter cycles", i), n_sh, tbl[i].e_sh);
            check($sformatf("vec%0d tpulse cycles", i), n_tp, tbl[i].e_tp);
            check($sformatf("vec%0d t0 cycles", i), n_t0, tbl[i].e_t0);
            check($sformatf("vec%0d busy cycles", i), n_busy, tbl[i].e_busy);
            check($sformatf("vec%0d done cycle", i), done_cyc, tbl[i].e_done);
            check($sformatf("vec%0d frame count", i), fc_end, tbl[i].e_fc);
        end

        // Reset in the middle of an open shutter.
        c = '{1, 0, 20, 0, 1, 1, 2, 1};
        drive_cfg(c);
        bus.START = 1'b1;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre-reset shutter", int'(bus.SHUTTER), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid-run reset outputs", int'({bus.FRAME_CNT, bus.SHUTTER, bus.TPULSE, bus.T0_SYNC, bus.BUSY, bus.DONE}), 0);
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            cnt += int'(bus.DONE);
        end
        check("post-reset done count", cnt, 0);
        bus.START = 1'b1;
        @(posedge clk); #1;
        bus.START = 1'b0;
        check("post-reset start {busy,fc}", int'({bus.BUSY, bus.FRAME_CNT}), 1 << RW);
        bus.ABORT = 1'b1;
        @(posedge clk); #1;
        bus.ABORT = 1'b0;
        check("post-reset abort done", int'({bus.BUSY, bus.DONE}), 1);
        @(posedge clk); #1;

        for (int r = 0; r < 25; r++) begin
            c.t0en  = int'($urandom_range(0, 1));
            c.delay = int'($urandom_range(0, 5));
            c.len   = int'($urandom_range(0, 8));
            c.gap   = int'($urandom_range(0, 4));
            c.rep   = int'($urandom_range(0, 4));
            c.tpen  = int'($urandom_range(0, 1));
            c.per   = int'($urandom_range(0, 5));
            c.high  = int'($urandom_range(0, 6));
            ab = 0;
            if (c.rep == 0 || $urandom_range(0, 2) == 0) ab = int'($urandom_range(1, 60));
            run(100 + r, c, ab, 1'($urandom), n_sh, n_tp, n_t0, n_busy, done_cyc, fc_end);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
